// File: rtl/demux1an_param.sv
// demux1an_param: 1-to-N demultiplexer with one registered holding slot per
// output channel. A word is steered either to an explicit channel (mode=0)
// or to the round-robin pointer (mode=1). Each channel keeps its word until
// that channel's consumer takes it.
//
// Handshake: a word moves on the producer side in any cycle where
// valid_in & ready_in are high at the rising clock edge. It moves on
// channel i in any cycle where valid_out[i] & ready_out[i] are high at the
// edge. Once valid is raised, it and the data are held until the transfer.
// ready_in never looks at valid_in.
module demux1an_param #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 mode,
    input  logic [SELW-1:0]      selector,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 ready_in,
    output logic [N-1:0]         valid_out,
    output logic [N*WIDTH-1:0]   data_out,
    input  logic [N-1:0]         ready_out,
    output logic [SELW-1:0]      rr_ptr,
    output logic                 sel_err
);

    // One extra bit lets a selector value be compared against N even when
    // N is a power of two.
    localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

    logic [SELW-1:0] target;
    logic            in_range;
    logic [N-1:0]    tgt_hot;
    logic            accept;

    // Choose the target channel for this cycle and decode it to one-hot.
    // An out-of-range target decodes to no channel at all.
    always_comb begin
        target   = mode ? rr_ptr : selector;
        in_range = ({1'b0, target} < N_EXT);
        tgt_hot  = '0;
        for (int i = 0; i < N; i++) begin
            if (in_range && (target == SELW'(i))) begin
                tgt_hot[i] = 1'b1;
            end
        end
    end

    // An out-of-range word is always taken and then dropped. An in-range
    // word is taken when its slot is empty or is draining in this same cycle.
    always_comb begin
        ready_in = ~in_range | (|(tgt_hot & (~valid_out | ready_out)));
        accept   = valid_in & ready_in;
    end

    // Per-channel holding slot. A load wins over a drain, so a slot that
    // drains and reloads in the same cycle has no bubble.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_out <= '0;
            data_out  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept && tgt_hot[i]) begin
                    valid_out[i]                <= 1'b1;
                    data_out[i*WIDTH +: WIDTH]  <= data_in;
                end else if (valid_out[i] && ready_out[i]) begin
                    valid_out[i] <= 1'b0;
                end
            end
        end
    end

    // The round-robin pointer advances only on an in-range accept in
    // round-robin mode. It wraps from N-1 to 0.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr <= '0;
        end else if (accept && in_range && mode) begin
            rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + SELW'(1);
        end
    end

    // Pulse sel_err for one cycle after each dropped out-of-range word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= accept & ~in_range;
        end
    end

endmodule

// File: tb/tb_demux1an_param.sv
// Bench for demux1an_param. Instance 0 uses N=4 and instance 1 uses N=3,
// which makes an out-of-range selector reachable. Each channel is modelled
// as a one-deep queue of expected words. The driver pushes a word when the
// model says it was accepted. A separate monitor pops and compares the word
// whenever the DUT transfers on that channel.
module tb_demux1an_param;

    logic clk;
    logic reset_L;

    logic [1:0]       mode_v;
    logic [1:0][1:0]  sel_v;
    logic [1:0]       vin_v;
    logic [1:0][7:0]  din_v;
    logic [1:0][3:0]  rout_v;

    logic [1:0]       rin_v;
    logic [3:0]       vout4;
    logic [2:0]       vout3;
    logic [31:0]      dout4;
    logic [23:0]      dout3;
    logic [1:0]       rr4;
    logic [1:0]       rr3;
    logic [1:0]       serr_v;

    logic [1:0][3:0]  vout_v;
    logic [1:0][31:0] dout_v;
    logic [1:0][1:0]  rr_v;

    assign vout_v[0] = vout4;
    assign vout_v[1] = {1'b0, vout3};
    assign dout_v[0] = dout4;
    assign dout_v[1] = {8'h00, dout3};
    assign rr_v[0]   = rr4;
    assign rr_v[1]   = rr3;

    demux1an_param #(.WIDTH(8), .N(4)) dut4 (
        .clk(clk), .reset_L(reset_L), .mode(mode_v[0]), .selector(sel_v[0]),
        .valid_in(vin_v[0]), .data_in(din_v[0]), .ready_in(rin_v[0]),
        .valid_out(vout4), .data_out(dout4), .ready_out(rout_v[0]),
        .rr_ptr(rr4), .sel_err(serr_v[0])
    );

    demux1an_param #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .reset_L(reset_L), .mode(mode_v[1]), .selector(sel_v[1]),
        .valid_in(vin_v[1]), .data_in(din_v[1]), .ready_in(rin_v[1]),
        .valid_out(vout3), .data_out(dout3), .ready_out(rout_v[1][2:0]),
        .rr_ptr(rr3), .sel_err(serr_v[1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[8][$];   // index = dut*4 + channel
    int         mdl_rr[2];
    bit         mdl_serr[2];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    // Inputs change only just after a rising edge, so the values seen at the
    // falling edge are what the next rising edge acts on.
    always @(negedge clk) begin
        if (reset_L) begin
            for (int w = 0; w < 2; w++) begin
                for (int ch = 0; ch < ((w == 1) ? 3 : 4); ch++) begin
                    if (vout_v[w][ch] && rout_v[w][ch]) begin
                        if (exp_q[w*4+ch].size() == 0) begin
                            check($sformatf("unexpected_word d%0d ch%0d", w, ch), 1, 0);
                        end else begin
                            check($sformatf("data d%0d ch%0d", w, ch),
                                  {24'h0, dout_v[w][ch*8 +: 8]}, {24'h0, exp_q[w*4+ch].pop_front()});
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver + reference model ----------------
    // Presents one cycle of stimulus to instance w. It checks the visible
    // state against the model, then commits the model for the next edge.
    task automatic step(input int w, input bit m, input logic [1:0] s, input bit v,
                        input logic [7:0] d, input logic [3:0] ro);
        int       n;
        int       t;
        bit       oor;
        bit       exp_rdy;
        bit       acc;
        logic [3:0] exp_valid;
        @(posedge clk);
        #1;
        mode_v[w] = m;
        sel_v[w]  = s;
        vin_v[w]  = v;
        din_v[w]  = d;
        rout_v[w] = ro;
        #1;
        n = (w == 1) ? 3 : 4;
        exp_valid = '0;
        for (int ch = 0; ch < n; ch++) exp_valid[ch] = (exp_q[w*4+ch].size() != 0);
        check($sformatf("valid_out d%0d", w), {28'h0, vout_v[w]}, {28'h0, exp_valid});
        check($sformatf("rr_ptr d%0d", w), {30'h0, rr_v[w]}, mdl_rr[w]);
        check($sformatf("sel_err d%0d", w), {31'h0, serr_v[w]}, {31'h0, mdl_serr[w]});
        t   = m ? mdl_rr[w] : int'(s);
        oor = (t >= n);
        exp_rdy = oor || (exp_q[w*4+t].size() == 0) || ro[t];
        check($sformatf("ready_in d%0d", w), {31'h0, rin_v[w]}, {31'h0, exp_rdy});
        acc = v && exp_rdy;
        mdl_serr[w] = acc && oor;
        if (acc && !oor) begin
            exp_q[w*4+t].push_back(d);
            if (m) mdl_rr[w] = (mdl_rr[w] + 1) % n;
        end
    endtask

    task automatic drain(input int w);
        for (int i = 0; i < 3; i++) step(w, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
    endtask

    task automatic random_phase(input int w, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(w, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)));
        end
        drain(w);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_L = 1'b0;
        mode_v = '0; sel_v = '0; vin_v = '0; din_v = '0; rout_v = '0;
        mdl_rr[0] = 0; mdl_rr[1] = 0;
        mdl_serr[0] = 0; mdl_serr[1] = 0;
        repeat (3) @(posedge clk);
        #2;
        check("reset data_out d0", dout4, 32'h0);
        check("reset data_out d1", {8'h0, dout3}, 32'h0);
        reset_L = 1'b1;

        // Explicit steering: 0xA1 to channel 2, consumer always ready.
        step(0, 1'b0, 2'd2, 1'b1, 8'hA1, 4'hF);
        step(0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        step(0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);

        // Backpressure, then a refill with no bubble on channel 1.
        step(0, 1'b0, 2'd1, 1'b1, 8'h11, 4'b1101);
        step(0, 1'b0, 2'd1, 1'b1, 8'h22, 4'b1101);
        step(0, 1'b0, 2'd1, 1'b1, 8'h22, 4'b1101);
        step(0, 1'b0, 2'd1, 1'b1, 8'h22, 4'b1111);
        step(0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        drain(0);

        // Round-robin distribution of 0x01..0x06.
        for (int i = 1; i <= 6; i++) step(0, 1'b1, 2'd0, 1'b1, 8'(i), 4'hF);
        step(0, 1'b1, 2'd0, 1'b0, 8'h00, 4'hF);
        check("rr_end", {30'h0, rr4}, 32'd2);

        // Move the pointer to 1 and load channel 1 while it is stalled. Then
        // round-robin must stall with the pointer held.
        for (int i = 0; i < 3; i++) step(0, 1'b1, 2'd0, 1'b1, 8'h30 + 8'(i), 4'hF);
        step(0, 1'b0, 2'd1, 1'b1, 8'h77, 4'b1101);
        step(0, 1'b1, 2'd0, 1'b1, 8'h88, 4'b1101);
        step(0, 1'b1, 2'd0, 1'b1, 8'h88, 4'b1101);
        check("rr_hold", {30'h0, rr4}, 32'd1);
        step(0, 1'b1, 2'd0, 1'b1, 8'h88, 4'b1111);
        drain(0);

        // Out-of-range drops on the N=3 instance, single and back-to-back.
        step(1, 1'b0, 2'd3, 1'b1, 8'h55, 4'hF);
        step(1, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        step(1, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        step(1, 1'b0, 2'd3, 1'b1, 8'h56, 4'hF);
        step(1, 1'b0, 2'd3, 1'b1, 8'h57, 4'hF);
        step(1, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        drain(1);

        // Randomized traffic on both instances.
        random_phase(0, 400);
        random_phase(1, 400);

        // Async reset mid-stream: channels 0 and 3 full, rr_ptr = 2.
        for (int i = 0; i < 4 && mdl_rr[0] != 2; i++)
            step(0, 1'b1, 2'd0, 1'b1, 8'($urandom_range(0, 255)), 4'hF);
        drain(0);
        step(0, 1'b0, 2'd0, 1'b1, 8'hC0, 4'h0);
        step(0, 1'b0, 2'd3, 1'b1, 8'hC3, 4'h0);
        step(0, 1'b1, 2'd0, 1'b0, 8'h00, 4'h0);
        #1;
        reset_L = 1'b0;
        #1;
        check("async valid_out", {28'h0, vout4}, 32'h0);
        check("async data_out", dout4, 32'h0);
        check("async rr_ptr", {30'h0, rr4}, 32'h0);
        for (int i = 0; i < 8; i++) exp_q[i].delete();
        mdl_rr[0] = 0; mdl_rr[1] = 0;
        mdl_serr[0] = 0; mdl_serr[1] = 0;
        reset_L = 1'b1;

        // After reset any target is ready.
        step(0, 1'b0, 2'd3, 1'b1, 8'h5A, 4'h0);
        step(0, 1'b1, 2'd0, 1'b0, 8'h00, 4'hF);
        step(1, 1'b0, 2'd1, 1'b1, 8'h6B, 4'h0);
        step(1, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        drain(0);
        drain(1);

        for (int i = 0; i < 8; i++)
            check($sformatf("left_over q%0d", i), exp_q[i].size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
